pll_reset_sequencer: RTL

- Supervises the Ethernet/UDP clock PLL: issues PLL reset pulses, waits for lock with timeout and bounded retries, and qualifies lock stability.
- Releases the MAC and UDP-stack domain resets in a fixed order once lock is qualified.
- On lock loss or soft request, re-asserts the domain resets and re-runs the sequence.
- Runs on the free-running 60 MHz reference clock, alongside the PLL wrapper in the UDP top.

---
 rtl/pll_reset_sequencer_if.sv | 38 +++
 rtl/pll_reset_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer_if.sv
// Control/status bundle between the PLL reset sequencer and the UDP top.
// The master side is the sequencer itself (it drives the resets and status);
// the slave side is the PLL wrapper / system control that supplies lock and requests.
interface pll_reset_sequencer_if;
  logic        locked;      // raw PLL lock, asynchronous to Clk
  logic        soft_req;    // single-cycle request to force a full re-lock
  logic        pll_rst;
  logic        mac_rst;
  logic        udp_rst;
  logic        lock_ok;
  logic        fail;
  logic [3:0]  retry_cnt;
  logic [15:0] relock_cnt;

  modport master (
    input  locked,
    input  soft_req,
    output pll_rst,
    output mac_rst,
    output udp_rst,
    output lock_ok,
    output fail,
    output retry_cnt,
    output relock_cnt
  );

  modport slave (
    output locked,
    output soft_req,
    input  pll_rst,
    input  mac_rst,
    input  udp_rst,
    input  lock_ok,
    input  fail,
    input  retry_cnt,
    input  relock_cnt
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, waits for lock with timeout and bounded
// retries, qualifies lock stability, then releases the MAC and UDP domain resets in order.
// Lock loss or a soft request re-asserts the domain resets and re-runs the sequence.
module pll_reset_sequencer #(
  parameter int unsigned RST_PULSE_CYC    = 20,
  parameter int unsigned LOCK_TIMEOUT_CYC = 60000,
  parameter int unsigned LOCK_STABLE_CYC  = 256,
  parameter int unsigned MAX_RETRY        = 7,
  parameter int unsigned RELEASE_GAP_CYC  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  pll_reset_sequencer_if.master ctrl_io
);

  typedef enum logic [2:0] {
    StResetPll,
    StWaitLock,
    StStable,
    StRelease,
    StRun,
    StFail
  } state_e;

  localparam logic [15:0] PulseLast   = 16'(RST_PULSE_CYC - 1);
  localparam logic [15:0] TimeoutLast = 16'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [16:0] StableNeed  = 17'(LOCK_STABLE_CYC);
  localparam logic [15:0] GapLast     = 16'(RELEASE_GAP_CYC - 1);
  localparam logic [3:0]  RetryMax    = 4'(MAX_RETRY);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        pll_rst_q, pll_rst_d;
  logic        mac_rst_q, mac_rst_d;
  logic        udp_rst_q, udp_rst_d;
  logic        lock_ok_q, lock_ok_d;
  logic        fail_q, fail_d;
  logic [3:0]  retry_cnt_q, retry_cnt_d;
  logic [15:0] relock_cnt_q, relock_cnt_d;
  logic [1:0]  sync_q;

  logic        locked_s;
  logic [3:0]  retry_inc;
  logic [15:0] relock_inc;
  logic [16:0] stable_run;

  // Two-flop synchroniser for the asynchronous PLL lock
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], ctrl_io.locked};
    end
  end

  assign locked_s  = sync_q[1];
  assign retry_inc = retry_cnt_q + 4'd1;
  assign relock_inc = (relock_cnt_q == 16'hFFFF) ? relock_cnt_q : relock_cnt_q + 16'd1;
  // Consecutive high samples of locked_s including the one that caused STABLE entry
  // and the one being sampled now.
  assign stable_run = {1'b0, cnt_q} + 17'd2;

  // Next-state and registered-output decode; soft_req > lock loss > timer completion
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 16'd1;
    pll_rst_d    = pll_rst_q;
    mac_rst_d    = mac_rst_q;
    udp_rst_d    = udp_rst_q;
    lock_ok_d    = lock_ok_q;
    fail_d       = fail_q;
    retry_cnt_d  = retry_cnt_q;
    relock_cnt_d = relock_cnt_q;

    if (ctrl_io.soft_req && (state_q != StResetPll)) begin
      state_d     = StResetPll;
      retry_cnt_d = 4'd0;
      fail_d      = 1'b0;
    end else begin
      unique case (state_q)
        StResetPll: begin
          if (cnt_q == PulseLast) begin
            state_d   = StWaitLock;
            pll_rst_d = 1'b0;
          end
        end
        StWaitLock: begin
          if (locked_s) begin
            state_d = StStable;
          end else if (cnt_q == TimeoutLast) begin
            retry_cnt_d = retry_inc;
            if (retry_inc == RetryMax) begin
              state_d   = StFail;
              fail_d    = 1'b1;
              pll_rst_d = 1'b0;
            end else begin
              state_d = StResetPll;
            end
          end
        end
        StStable: begin
          // A dropout is not a retry: go back for a fresh timeout window
          if (!locked_s) begin
            state_d = StWaitLock;
          end else if (stable_run >= StableNeed) begin
            state_d   = StRelease;
            mac_rst_d = 1'b0;
          end
        end
        StRelease: begin
          if (!locked_s) begin
            state_d      = StResetPll;
            relock_cnt_d = relock_inc;
          end else if (cnt_q == GapLast) begin
            state_d     = StRun;
            udp_rst_d   = 1'b0;
            lock_ok_d   = 1'b1;
            retry_cnt_d = 4'd0;
          end
        end
        StRun: begin
          cnt_d = cnt_q;
          if (!locked_s) begin
            state_d      = StResetPll;
            relock_cnt_d = relock_inc;
          end
        end
        StFail: begin
          cnt_d = cnt_q;
        end
        default: begin
          state_d = StResetPll;
        end
      endcase
    end

    if (state_d != state_q) begin
      cnt_d = 16'd0;
    end

    // Every way into RESET_PLL re-asserts all resets and drops lock_ok
    if ((state_d == StResetPll) && (state_q != StResetPll)) begin
      pll_rst_d = 1'b1;
      mac_rst_d = 1'b1;
      udp_rst_d = 1'b1;
      lock_ok_d = 1'b0;
    end
  end

  // State, counter and output registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StResetPll;
      cnt_q        <= 16'd0;
      pll_rst_q    <= 1'b1;
      mac_rst_q    <= 1'b1;
      udp_rst_q    <= 1'b1;
      lock_ok_q    <= 1'b0;
      fail_q       <= 1'b0;
      retry_cnt_q  <= 4'd0;
      relock_cnt_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pll_rst_q    <= pll_rst_d;
      mac_rst_q    <= mac_rst_d;
      udp_rst_q    <= udp_rst_d;
      lock_ok_q    <= lock_ok_d;
      fail_q       <= fail_d;
      retry_cnt_q  <= retry_cnt_d;
      relock_cnt_q <= relock_cnt_d;
    end
  end

  assign ctrl_io.pll_rst    = pll_rst_q;
  assign ctrl_io.mac_rst    = mac_rst_q;
  assign ctrl_io.udp_rst    = udp_rst_q;
  assign ctrl_io.lock_ok    = lock_ok_q;
  assign ctrl_io.fail       = fail_q;
  assign ctrl_io.retry_cnt  = retry_cnt_q;
  assign ctrl_io.relock_cnt = relock_cnt_q;

endmodule
